// File: rtl/fifo_traffic_driver.sv
// Stimulus engine for a synchronous FIFO: LFSR write traffic in four modes, in-order
// read-back checking against a reference LFSR, and saturating event counters.
module fifo_traffic_driver #(
  parameter int          FIFO_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_ops,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_ack_cnt,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underflow_cnt,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           mismatch_cnt
);

  if (FIFO_WIDTH < 8 || FIFO_WIDTH > 16 || FIFO_DEPTH < 1 || SEED == 16'h0000) begin : g_param_check
    $error("fifo_traffic_driver: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    MIXED  = 3'd2,
    STRESS = 3'd3,
    DRAIN  = 3'd4,
    SETTLE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q;
  logic [15:0] num_ops_q;
  logic [15:0] op_cnt;
  logic [15:0] w_lfsr, r_lfsr, c_lfsr;
  logic        cmp_pend;

  logic start_acc, wr_acc, rd_acc, op_last, data_bad;
  state_t start_target;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_acc = start && (state == IDLE || state == DONE);
  assign wr_acc    = wr_en && !full;
  assign rd_acc    = rd_en && !empty;
  assign op_last   = (op_cnt == num_ops_q - 16'd1);
  assign data_bad  = (data_out != r_lfsr[FIFO_WIDTH-1:0]);

  assign busy    = (state == FILL) || (state == MIXED) || (state == STRESS) ||
                   (state == DRAIN) || (state == SETTLE);
  assign done    = (state == DONE);
  assign data_in = busy ? w_lfsr[FIFO_WIDTH-1:0] : '0;

  // A zero-length run skips straight to draining (or settling for underflow stress)
  always_comb begin
    start_target = IDLE;
    if (num_ops == 16'd0) begin
      start_target = (mode == 2'd3) ? SETTLE : DRAIN;
    end else begin
      case (mode)
        2'd0:    start_target = FILL;
        2'd1:    start_target = MIXED;
        default: start_target = STRESS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = start_target;
      end
      FILL: begin
        wr_en = !full;
        if (full || op_last) state_nxt = DRAIN;
      end
      MIXED: begin
        wr_en = c_lfsr[0] && !full;
        rd_en = c_lfsr[1] && !empty;
        if (op_last) state_nxt = DRAIN;
      end
      STRESS: begin
        if (mode_q == 2'd3) rd_en = 1'b1;
        else                wr_en = 1'b1;
        if (op_last) state_nxt = (mode_q == 2'd3) ? SETTLE : DRAIN;
      end
      DRAIN: begin
        rd_en = !empty;
        if (empty) state_nxt = SETTLE;
      end
      SETTLE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // FILL only counts writes that land; MIXED and STRESS count elapsed cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'd0;
      num_ops_q <= 16'd0;
      op_cnt    <= 16'd0;
    end else if (start_acc) begin
      mode_q    <= mode;
      num_ops_q <= num_ops;
      op_cnt    <= 16'd0;
    end else if ((state == FILL && wr_acc) || state == MIXED || state == STRESS) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_lfsr   <= SEED;
      r_lfsr   <= SEED;
      c_lfsr   <= SEED;
      cmp_pend <= 1'b0;
    end else if (start_acc) begin
      w_lfsr   <= SEED;
      r_lfsr   <= SEED;
      c_lfsr   <= SEED;
      cmp_pend <= 1'b0;
    end else begin
      if (busy)     c_lfsr <= lfsr_next(c_lfsr);
      if (wr_acc)   w_lfsr <= lfsr_next(w_lfsr);
      if (cmp_pend) r_lfsr <= lfsr_next(r_lfsr);
      cmp_pend <= rd_acc;
    end
  end

  // Status pulses arrive a cycle late, so they are still counted in SETTLE and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_cnt    <= 16'd0;
      overflow_cnt  <= 16'd0;
      underflow_cnt <= 16'd0;
      rd_cnt        <= 16'd0;
      mismatch_cnt  <= 16'd0;
    end else if (start_acc) begin
      wr_ack_cnt    <= 16'd0;
      overflow_cnt  <= 16'd0;
      underflow_cnt <= 16'd0;
      rd_cnt        <= 16'd0;
      mismatch_cnt  <= 16'd0;
    end else begin
      if (rd_acc)               rd_cnt       <= sat_inc(rd_cnt);
      if (cmp_pend && data_bad) mismatch_cnt <= sat_inc(mismatch_cnt);
      if (state != IDLE) begin
        if (wr_ack)    wr_ack_cnt    <= sat_inc(wr_ack_cnt);
        if (overflow)  overflow_cnt  <= sat_inc(overflow_cnt);
        if (underflow) underflow_cnt <= sat_inc(underflow_cnt);
      end
    end
  end

endmodule

// File: tb/tb_fifo_traffic_driver.sv
// Bench for fifo_traffic_driver: behavioural depth-8 FIFO, write-data scoreboard,
// table of whole-run vectors, and hand sequences for timing and mid-run reset.
module tb_fifo_traffic_driver;

  localparam int          W     = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [1:0]    mode;
  logic [15:0]   num_ops;
  logic [W-1:0]  data_in, data_out;
  logic          wr_en, rd_en, full, empty, wr_ack, overflow, underflow, busy, done;
  logic [15:0]   wr_ack_cnt, overflow_cnt, underflow_cnt, rd_cnt, mismatch_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  int           bench_wr, bench_rd;
  bit           inject;
  int           inject_at;
  int           fifo_rd_total;

  fifo_traffic_driver #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_ops(num_ops),
    .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .full(full), .empty(empty), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .busy(busy), .done(done), .wr_ack_cnt(wr_ack_cnt), .overflow_cnt(overflow_cnt),
    .underflow_cnt(underflow_cnt), .rd_cnt(rd_cnt), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO with registered read data and status pulses
  logic [W-1:0] mem [DEPTH];
  logic [2:0]   wp, rp;
  logic [3:0]   count;
  assign full  = (count == 4'(DEPTH));
  assign empty = (count == 4'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 3'd0; rp <= 3'd0; count <= 4'd0; data_out <= '0;
      wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0; fifo_rd_total <= 0;
    end else begin
      wr_ack    <= wr_en && !full;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_en && !full) begin
        mem[wp] <= data_in;
        wp      <= wp + 3'd1;
      end
      if (rd_en && !empty) begin
        data_out      <= mem[rp] ^ ((inject && fifo_rd_total == inject_at) ? W'(1) : W'(0));
        rp            <= rp + 3'd1;
        fifo_rd_total <= fifo_rd_total + 1;
      end
      count <= count + ((wr_en && !full) ? 4'd1 : 4'd0) - ((rd_en && !empty) ? 4'd1 : 4'd0);
    end
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every accepted write must carry the next word of the seed sequence
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en && !full) begin
        bench_wr++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL wr_data: write with no expected word queued, got %0h", data_in);
        end else begin
          checkOutput("wr_data", 32'(data_in), 32'(exp_q.pop_front()));
        end
      end
      if (rd_en && !empty) bench_rd++;
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] n, input bit inj);
    logic [15:0] s;
    @(negedge clk);
    exp_q.delete();
    s = SEED;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(s[W-1:0]);
      s = ref_step(s);
    end
    bench_wr  = 0;
    bench_rd  = 0;
    inject    = inj;
    inject_at = fifo_rd_total + 1;
    start     = 1'b1;
    mode      = m;
    num_ops   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] num_ops;
    bit          inject;
    bit          restart;
    bit          balance;
    int          exp_wr, exp_ovf, exp_udf, exp_rd, exp_mis;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  initial begin
    int cyc;
    vecs[0] = '{2'd0, 16'd5,   1'b0, 1'b0, 1'b0, 5, 0, 0, 5, 0};
    vecs[1] = '{2'd0, 16'd12,  1'b0, 1'b0, 1'b0, 8, 0, 0, 8, 0};
    vecs[2] = '{2'd2, 16'd12,  1'b0, 1'b1, 1'b0, 8, 4, 0, 8, 0};
    vecs[3] = '{2'd3, 16'd3,   1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0};
    vecs[4] = '{2'd1, 16'd200, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
    vecs[5] = '{2'd0, 16'd5,   1'b1, 1'b0, 1'b0, 5, 0, 0, 5, 1};
    vecs[6] = '{2'd0, 16'd0,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[7] = '{2'd3, 16'd0,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[8] = '{2'd2, 16'd5,   1'b0, 1'b0, 1'b0, 5, 0, 0, 5, 0};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; num_ops = 16'd0;
    inject = 1'b0; inject_at = 0; bench_wr = 0; bench_rd = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data_in", 32'(data_in), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_ack_cnt", 32'(wr_ack_cnt), 32'd0);
    checkOutput("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].num_ops, vecs[i].inject);
      checkOutput($sformatf("v%0d_busy_at_start", i), 32'(busy), 32'd1);
      checkOutput($sformatf("v%0d_done_cleared", i), 32'(done), 32'd0);
      if (vecs[i].restart) begin
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 2'd3; num_ops = 16'd3;
        @(negedge clk);
        start = 1'b0;
      end
      waitDone(cyc);
      checkOutput($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d_mismatch_cnt", i), 32'(mismatch_cnt), 32'(vecs[i].exp_mis));
      checkOutput($sformatf("v%0d_fifo_empty", i), 32'(empty), 32'd1);
      if (vecs[i].balance) begin
        checkOutput($sformatf("v%0d_wr_ack_vs_writes", i), 32'(wr_ack_cnt), 32'(bench_wr));
        checkOutput($sformatf("v%0d_rd_cnt_vs_reads", i), 32'(rd_cnt), 32'(bench_rd));
        checkOutput($sformatf("v%0d_wr_ack_vs_rd_cnt", i), 32'(wr_ack_cnt), 32'(rd_cnt));
        checkOutput($sformatf("v%0d_overflow_cnt", i), 32'(overflow_cnt), 32'd0);
      end else begin
        checkOutput($sformatf("v%0d_wr_ack_cnt", i), 32'(wr_ack_cnt), 32'(vecs[i].exp_wr));
        checkOutput($sformatf("v%0d_overflow_cnt", i), 32'(overflow_cnt), 32'(vecs[i].exp_ovf));
        checkOutput($sformatf("v%0d_underflow_cnt", i), 32'(underflow_cnt), 32'(vecs[i].exp_udf));
        checkOutput($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
      end
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d_done_held", i), 32'(done), 32'd1);
    end

    // Underflow stress: three stress cycles plus one settle cycle before DONE
    applyStimulus(2'd3, 16'd3, 1'b0);
    waitDone(cyc);
    checkOutput("m3_done_latency", 32'(cyc), 32'd4);
    checkOutput("m3_underflow_cnt", 32'(underflow_cnt), 32'd3);

    // Reset in the middle of a FILL run, then a clean run afterwards
    applyStimulus(2'd0, 16'd6, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("midrst_data_in", 32'(data_in), 32'd0);
    checkOutput("midrst_wr_ack_cnt", 32'(wr_ack_cnt), 32'd0);
    checkOutput("midrst_rd_cnt", 32'(rd_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2'd0, 16'd5, 1'b0);
    waitDone(cyc);
    checkOutput("postrst_wr_ack_cnt", 32'(wr_ack_cnt), 32'd5);
    checkOutput("postrst_rd_cnt", 32'(rd_cnt), 32'd5);
    checkOutput("postrst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    checkOutput("postrst_wr_seen", 32'(bench_wr), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
